audio_driver_fifo_if: RTL

//  Buffered successor to the single-word audio driver interface.
//  - Accepts DATA_SIZE-bit samples on a valid/ready stream into a DEPTH-entry FIFO.
//  - Exposes data, status and control registers on an Avalon-MM slave (read latency 1).
//  - Drives a level irq when the fill level reaches a programmable threshold, or on overflow.

---
 rtl/driver_if_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/audio_driver_fifo_if.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/driver_if_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : driver_if_pkg
// Brief  : Register map, bit positions and control type shared by the
//          buffered audio driver interface.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package driver_if_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_CLEAR  = 2'd3;

  localparam int STAT_EMPTY      = 8;
  localparam int STAT_FULL       = 9;
  localparam int STAT_OVF        = 10;
  localparam int STAT_UNF        = 11;
  localparam int CTRL_IRQ_EN     = 0;
  localparam int CTRL_THRESH_LSB = 8;
  localparam int CLR_OVF         = 0;
  localparam int CLR_UNF         = 1;
  localparam int CLR_PEAK        = 2;

  typedef struct packed {
    logic       irq_en;
    logic [7:0] thresh;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sync_fifo
// Brief  : Single-clock FIFO with level/full/empty, no push-to-pop bypass.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_lw = c_aw + 1;

  generate
    if ((DEPTH < 2) || (DEPTH > 128) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of 2 in 2..128");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_lw-1:0]  r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == c_lw'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  // Pop is judged on the pre-edge level, so a push into an empty FIFO cannot be popped the same cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/audio_driver_fifo_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : audio_driver_fifo_if
// Brief  : Buffered audio sample driver: stream into a FIFO, Avalon-MM
//          register access, threshold/overflow irq. Optional peak
//          tracking when DRIVER_IF_PEAK_EN is defined.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module audio_driver_fifo_if
  import driver_if_pkg::*;
#(
  parameter int DATA_SIZE = 28,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  input  logic                 src_valid,
  input  logic [DATA_SIZE-1:0] src_data,
  output logic                 src_ready,
  output logic                 irq
);

  localparam int c_lw = $clog2(DEPTH) + 1;

  generate
    if ((DATA_SIZE < 1) || (DATA_SIZE > 32)) begin : g_bad_width
      $error("audio_driver_fifo_if: DATA_SIZE must be in 1..32");
    end
  endgenerate

  ctrl_t                r_ctrl;
  ctrl_t                w_ctrl_next;
  logic                 r_ovf;
  logic                 r_unf;
  logic                 r_irq;
  logic [31:0]          r_read_data;
  logic                 w_ovf_next;
  logic                 w_unf_next;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_clr_wr;
  logic [DATA_SIZE-1:0] w_head;
  logic [c_lw-1:0]      w_level;
  logic [c_lw-1:0]      w_level_next;
  logic                 w_full;
  logic                 w_empty;
  logic [7:0]           w_thresh_eff;
  logic [31:0]          w_status;
  logic [31:0]          w_ctrl_rd;
  logic [31:0]          w_clear_rd;
  logic [31:0]          w_rd_mux;
  logic                 w_unused;

  assign w_unused  = ^write_data;
  assign w_rd      = chipselect && read;
  assign w_wr      = chipselect && write && !w_rd;
  assign src_ready = !rst && !w_full;
  assign w_push    = src_valid && src_ready;
  assign w_pop     = w_rd && (address == REG_DATA) && !w_empty;
  assign w_clr_wr  = w_wr && (address == REG_CLEAR);
  assign read_data = r_read_data;
  assign irq       = r_irq;

  sync_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (src_data),
    .dout  (w_head),
    .level (w_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_level_next = w_level;
    if (w_push && !w_pop) w_level_next = w_level + 1'b1;
    if (!w_push && w_pop) w_level_next = w_level - 1'b1;
  end

  // Set terms sit outside the clear mask so a same-cycle set survives a clear.
  assign w_ovf_next = (src_valid && !src_ready && !rst) ||
                      (r_ovf && !(w_clr_wr && write_data[CLR_OVF]));
  assign w_unf_next = (w_rd && (address == REG_DATA) && w_empty) ||
                      (r_unf && !(w_clr_wr && write_data[CLR_UNF]));

  always_comb begin
    w_ctrl_next = r_ctrl;
    if (w_wr && (address == REG_CTRL)) begin
      w_ctrl_next.irq_en = write_data[CTRL_IRQ_EN];
      w_ctrl_next.thresh = write_data[CTRL_THRESH_LSB +: 8];
    end
  end

  assign w_thresh_eff = (w_ctrl_next.thresh == 8'd0) ? 8'd1 : w_ctrl_next.thresh;

`ifdef DRIVER_IF_PEAK_EN
  logic [DATA_SIZE-1:0] r_peak;
  logic [DATA_SIZE-1:0] w_peak_next;
  logic [DATA_SIZE-1:0] w_abs;

  // Two's-complement magnitude; the most-negative code maps to 2^(DATA_SIZE-1) unsigned.
  assign w_abs = src_data[DATA_SIZE-1] ? (~src_data + DATA_SIZE'(1)) : src_data;

  always_comb begin
    w_peak_next = r_peak;
    if (w_clr_wr && write_data[CLR_PEAK]) begin
      w_peak_next = w_push ? w_abs : '0;
    end else if (w_push && (w_abs > r_peak)) begin
      w_peak_next = w_abs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_peak <= '0;
    else     r_peak <= w_peak_next;
  end

  assign w_clear_rd = 32'(r_peak);
`else
  assign w_clear_rd = 32'd0;
`endif

  always_comb begin
    w_status                  = '0;
    w_status[7:0]             = 8'(w_level);
    w_status[STAT_EMPTY]      = w_empty;
    w_status[STAT_FULL]       = w_full;
    w_status[STAT_OVF]        = r_ovf;
    w_status[STAT_UNF]        = r_unf;
    w_ctrl_rd                 = '0;
    w_ctrl_rd[CTRL_IRQ_EN]    = r_ctrl.irq_en;
    w_ctrl_rd[CTRL_THRESH_LSB +: 8] = r_ctrl.thresh;
    w_rd_mux                  = '0;
    case (address)
      REG_DATA:   w_rd_mux = w_empty ? 32'd0 : 32'(w_head);
      REG_STATUS: w_rd_mux = w_status;
      REG_CTRL:   w_rd_mux = w_ctrl_rd;
      REG_CLEAR:  w_rd_mux = w_clear_rd;
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl.irq_en <= 1'b0;
      r_ctrl.thresh <= 8'(DEPTH / 2);
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
      r_irq         <= 1'b0;
      r_read_data   <= '0;
    end else begin
      r_ctrl <= w_ctrl_next;
      r_ovf  <= w_ovf_next;
      r_unf  <= w_unf_next;
      r_irq  <= w_ctrl_next.irq_en &&
                ((8'(w_level_next) >= w_thresh_eff) || w_ovf_next);
      if (w_rd) r_read_data <= w_rd_mux;
    end
  end

endmodule
`default_nettype wire
